// File: rtl/snn_image_loader.sv
// snn_image_loader
//   Collects one binary image from a byte-wide UART receiver into a 1-bit
//   pixel memory, launches snn_core, then sends the ASCII form of the
//   result digit back through the UART transmitter.
//
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   rx_rdy, rx_data   received byte (bit i -> pixel 8*byte_cnt+i)
//   clr_rx_rdy        one-cycle acknowledge of the current rx byte
//   addr_input_unit   pixel read address from snn_core
//   q_input           registered pixel read data (one-cycle latency)
//   start             one-cycle launch pulse to snn_core
//   done, digit       snn_core result handshake
//   tx_start, tx_data transmit request and ASCII result byte
//   tx_busy           transmitter busy
module snn_image_loader #(
  parameter int         IMG_BYTES  = 98,
  parameter logic [7:0] ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  localparam int NPIX = IMG_BYTES * 8;

  localparam logic [2:0] S_LOAD     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_TX  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [6:0]      byte_cnt_q, byte_cnt_d;
  logic            clr_q, clr_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            seen_busy_q, seen_busy_d;
  logic            wait_cnt_q, wait_cnt_d;
  logic            q_input_q;
  logic [NPIX-1:0] mem_q;

  // The receiver still shows rx_rdy during the acknowledge cycle, so a byte
  // is only taken when no acknowledge is outstanding.
  logic rx_take, wr_en;
  assign rx_take = rx_rdy && !clr_q;
  assign wr_en   = rx_take && (state_q == S_LOAD);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    clr_d       = rx_take;   // bytes outside LOAD are acked and dropped
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    seen_busy_d = seen_busy_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_LOAD: begin
        if (wr_en) begin
          if (byte_cnt_q == 7'(IMG_BYTES - 1)) begin
            byte_cnt_d = 7'd0;
            state_d    = S_LAUNCH;
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
          end
        end
      end
      S_LAUNCH: state_d = S_CLASSIFY;
      S_CLASSIFY: begin
        if (done) begin
          tx_data_d = ASCII_BASE + {4'h0, digit};
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          wait_cnt_d  = 1'b0;
          state_d     = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // Leave once busy has risen and fallen again, or after two idle
        // cycles if the transmitter never reports busy.
        if (tx_busy)                       seen_busy_d = 1'b1;
        else if (seen_busy_q || wait_cnt_q) state_d    = S_LOAD;
        else                               wait_cnt_d  = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      byte_cnt_q  <= 7'd0;
      clr_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      seen_busy_q <= 1'b0;
      wait_cnt_q  <= 1'b0;
      q_input_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      clr_q       <= clr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      seen_busy_q <= seen_busy_d;
      wait_cnt_q  <= wait_cnt_d;
      q_input_q   <= (addr_input_unit < 10'(NPIX)) ? mem_q[addr_input_unit] : 1'b0;
    end
  end

  // Pixel memory keeps its contents across reset; every image rewrites it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) mem_q[{byte_cnt_q, 3'(i)}] <= rx_data[i];
    end
  end

  assign clr_rx_rdy = clr_q;
  assign start      = (state_q == S_LAUNCH);
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign q_input    = q_input_q;

endmodule

// File: tb/tb_snn_image_loader.sv
module tb_snn_image_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       start;
  logic       done;
  logic [3:0] digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  int npass = 0;
  int ntotal = 0;
  int start_cnt = 0;
  int txs_cnt = 0;
  logic [31:0] sb_q[$];

  snn_image_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .addr_input_unit(addr_input_unit),
    .q_input(q_input), .start(start), .done(done), .digit(digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start)    start_cnt++;
    if (tx_start) txs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Receiver model: hold rx_rdy until acknowledged, then drop it.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (clr_rx_rdy) got = 1'b1;
    end
    rx_rdy = 1'b0;
    chk("rx_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic read_chk(input logic [9:0] a, input logic expv);
    logic [31:0] e;
    @(negedge clk);
    addr_input_unit = a;
    sb_q.push_back({31'd0, expv});
    @(negedge clk);
    e = sb_q.pop_front();
    chk($sformatf("q_input[%0d]", a), {31'd0, q_input}, e);
  endtask

  task automatic pulse_done(input logic [3:0] d);
    @(negedge clk);
    done = 1'b1; digit = d;
    @(negedge clk);
    done = 1'b0; digit = 4'h0;
  endtask

  // Wait for tx_start and compare tx_data against the scoreboard head.
  task automatic wait_tx(input int budget);
    logic seen;
    logic [31:0] e;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, e);
      end
    end
    chk("tx_start_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int s0, t0;
    logic [7:0] bits;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; addr_input_unit = 10'd0;
    done = 1'b0; digit = 4'h0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clr", {31'd0, clr_rx_rdy}, 0);
    chk("rst_start", {31'd0, start}, 0);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_q_input", {31'd0, q_input}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Image 1: all bytes A5.
    for (int i = 0; i < 97; i++) send_byte(8'hA5);
    chk("no_early_start1", start_cnt, 0);
    send_byte(8'hA5);
    repeat (3) @(posedge clk);
    chk("start_once1", start_cnt, 1);
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) read_chk(10'(i), bits[i]);
    read_chk(10'd783, 1'b1);

    // Byte arriving during classification is acked and discarded.
    send_byte(8'h5A);
    read_chk(10'd1, 1'b0);
    read_chk(10'd2, 1'b1);

    // done with digit 7, transmitter idle.
    sb_q.push_back(32'h37);
    pulse_done(4'd7);
    wait_tx(10);
    repeat (6) @(posedge clk);
    chk("tx_start_once1", txs_cnt, 1);

    // Image 2: byte 0 = 01, rest 0; also proves the injected byte did not count.
    s0 = start_cnt;
    send_byte(8'h01);
    for (int i = 1; i < 97; i++) send_byte(8'h00);
    chk("no_early_start2", start_cnt, s0);
    send_byte(8'h00);
    repeat (3) @(posedge clk);
    chk("start_once2", start_cnt, s0 + 1);
    read_chk(10'd0, 1'b1);
    read_chk(10'd1, 1'b0);
    read_chk(10'd8, 1'b0);
    read_chk(10'd783, 1'b0);
    read_chk(10'd1000, 1'b0);

    // Transmitter busy for 20 cycles while in SEND.
    tx_busy = 1'b1;
    t0 = txs_cnt;
    sb_q.push_back(32'h33);
    pulse_done(4'd3);
    repeat (20) @(posedge clk);
    #1;
    chk("tx_held_off", txs_cnt, t0);
    @(negedge clk); tx_busy = 1'b0;
    wait_tx(5);
    tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) @(posedge clk);
    chk("tx_start_once2", txs_cnt, t0 + 1);

    // done outside CLASSIFY is ignored.
    pulse_done(4'd9);
    repeat (4) @(posedge clk);
    #1;
    chk("done_ignored_cnt", txs_cnt, t0 + 1);
    chk("done_ignored_data", {24'd0, tx_data}, 32'h33);

    // Reset after 50 bytes abandons the partial image.
    for (int i = 0; i < 50; i++) send_byte(8'hFF);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx_data", {24'd0, tx_data}, 0);
    rst_n = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 97; i++) send_byte(8'h3C);
    repeat (3) @(posedge clk);
    chk("no_early_start3", start_cnt, s0);
    send_byte(8'h3C);
    repeat (3) @(posedge clk);
    chk("start_once3", start_cnt, s0 + 1);
    read_chk(10'd0, 1'b0);
    read_chk(10'd2, 1'b1);
    read_chk(10'd5, 1'b1);
    read_chk(10'd7, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
